// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants for the systolic feed sequencer.
// SYSTOLIC_FEED_GAP_EN selects half-rate feeding (one all-zero vector between
// operand vectors, doubled skew and drain counts).
package systolic_pkg;
  localparam int DEF_N          = 8;
  localparam int DEF_DATA_WIDTH = 8;

  // Address width that never collapses to zero bits for a 1-lane array.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ADDR_W = addr_w(DEF_N);

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CLEAR     = 3'd1;
  localparam state_t ST_WAIT_LOCK = 3'd2;
  localparam state_t ST_FEED      = 3'd3;
  localparam state_t ST_DRAIN     = 3'd4;

  // Cycles per operand vector on the feed side
`ifdef SYSTOLIC_FEED_GAP_EN
  localparam int FEED_STRIDE = 2;
`else
  localparam int FEED_STRIDE = 1;
`endif
endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// systolic_feed_ctrl_if: control, operand-buffer and array-side bundle.
// master = sequencer side, slave = environment (buffers, array, host).
interface systolic_feed_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int AW = addr_w(N);

  logic                            start;
  logic                            accumulate;
  logic                            busy;
  logic                            done;
  logic                            op_rd_en;
  logic [AW-1:0]                   op_rd_addr;
  logic [N-1:0][DATA_WIDTH-1:0]    a_col_data;
  logic [N-1:0][DATA_WIDTH-1:0]    b_row_data;
  logic                            arr_rst;
  logic                            arr_en;
  logic                            arr_locked;
  logic [N-1:0][DATA_WIDTH-1:0]    arr_a_flat;
  logic [N-1:0][DATA_WIDTH-1:0]    arr_b_flat;

  modport master (
    input  start, accumulate, a_col_data, b_row_data, arr_locked,
    output busy, done, op_rd_en, op_rd_addr, arr_rst, arr_en, arr_a_flat, arr_b_flat
  );

  modport slave (
    output start, accumulate, a_col_data, b_row_data, arr_locked,
    input  busy, done, op_rd_en, op_rd_addr, arr_rst, arr_en, arr_a_flat, arr_b_flat
  );
endinterface

// File: rtl/systolic_skew_line.sv
// systolic_skew_line: triangular delay; lane i is held i*STRIDE cycles,
// lane 0 passes straight through. Registers clear on reset so the line
// always flushes zeros.
module systolic_skew_line #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int STRIDE     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0][DATA_WIDTH-1:0] din,
  output logic [N-1:0][DATA_WIDTH-1:0] dout
);
  assign dout[0] = din[0];

  for (genvar i = 1; i < N; i++) begin : g_lane
    localparam int DEPTH = i * STRIDE;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr;

    // Shift register of DEPTH stages for lane i
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= '0;
      end else begin
        sr[0] <= din[i];
        for (int d = 1; d < DEPTH; d++) sr[d] <= sr[d-1];
      end
    end

    assign dout[i] = sr[DEPTH-1];
  end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: clears the array, waits for lock, streams N A-columns
// and N B-rows through a diagonal skew, then counts out the drain latency
// and pulses done. SYSTOLIC_FEED_GAP_EN enables half-rate feeding.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DRAIN_CYCLES = 2 * N
) (
  input logic                 clk,
  input logic                 rst,
  systolic_feed_ctrl_if.master bus
);
  localparam int AW        = addr_w(N);
  // done fires when the drain counter reaches DRAIN_LEN (skew flush + drain)
  localparam int DRAIN_LEN = FEED_STRIDE * (N - 1 + DRAIN_CYCLES);
  localparam int CW        = $clog2(DRAIN_LEN + 1);

  state_t        state, state_nx;
  logic [AW-1:0] k;
  logic [CW-1:0] dcnt;
  logic          clr_cnt;
  logic          rd_en;
  logic          rd_vld;
  logic          k_step;
  logic          feed_last;
  logic          drain_end;
  logic          arr_rst_q;
  logic [N-1:0][DATA_WIDTH-1:0] a_gate, b_gate;

`ifdef SYSTOLIC_FEED_GAP_EN
  logic phase;  // 0 = read cycle, 1 = gap cycle

  // Alternate read/gap while feeding
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) phase <= 1'b0;
    else      phase <= (state == ST_FEED) ? ~phase : 1'b0;
  end

  assign rd_en  = (state == ST_FEED) && !phase;
  assign k_step = phase;
`else
  assign rd_en  = (state == ST_FEED);
  assign k_step = 1'b1;
`endif

  assign feed_last = (k == AW'(N - 1)) && k_step;
  assign drain_end = (state == ST_DRAIN) && (dcnt == CW'(DRAIN_LEN));

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      if (bus.start) state_nx = bus.accumulate ? ST_WAIT_LOCK : ST_CLEAR;
      ST_CLEAR:     if (clr_cnt) state_nx = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (bus.arr_locked) state_nx = ST_FEED;
      ST_FEED:      if (feed_last) state_nx = ST_DRAIN;
      ST_DRAIN:     if (drain_end) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // State, counters, read-valid and registered array reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      dcnt      <= '0;
      clr_cnt   <= 1'b0;
      rd_vld    <= 1'b0;
      arr_rst_q <= 1'b1;
    end else begin
      state     <= state_nx;
      clr_cnt   <= (state == ST_CLEAR) && !clr_cnt;
      rd_vld    <= rd_en;
      arr_rst_q <= (state_nx == ST_CLEAR);
      if (state != ST_FEED) k <= '0;
      else if (k_step)      k <= feed_last ? '0 : k + 1'b1;
      dcnt <= (state == ST_DRAIN && !drain_end) ? dcnt + 1'b1 : '0;
    end
  end

  // Buffer data is only trusted the cycle after a read strobe
  assign a_gate = rd_vld ? bus.a_col_data : '0;
  assign b_gate = rd_vld ? bus.b_row_data : '0;

  systolic_skew_line #(.N(N), .DATA_WIDTH(DATA_WIDTH), .STRIDE(FEED_STRIDE)) u_skew_a (
    .clk(clk), .rst(rst), .din(a_gate), .dout(bus.arr_a_flat)
  );

  systolic_skew_line #(.N(N), .DATA_WIDTH(DATA_WIDTH), .STRIDE(FEED_STRIDE)) u_skew_b (
    .clk(clk), .rst(rst), .din(b_gate), .dout(bus.arr_b_flat)
  );

  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = drain_end;
  assign bus.op_rd_en   = rd_en;
  assign bus.op_rd_addr = k;
  assign bus.arr_en     = (state == ST_WAIT_LOCK) || (state == ST_FEED) || (state == ST_DRAIN);
  assign bus.arr_rst    = arr_rst_q;
endmodule
